// File: rtl/fruit_pkg.sv
// Shared types and default constants for the fruit physics engine.
// FRAC_W and V_W are fixed here because the slot struct width depends on them.
package fruit_pkg;

    localparam int unsigned FRAC_W    = 4;
    localparam int unsigned V_W       = 12;
    localparam int unsigned INT_W     = 10;
    localparam int unsigned POS_W     = INT_W + FRAC_W;
    localparam int unsigned G_W       = 8;
    localparam int unsigned DEF_X_MAX = 639;
    localparam int unsigned DEF_Y_MAX = 479;

    typedef enum logic {
        IDLE,
        SWEEP
    } fruit_state_t;

    typedef struct packed {
        logic                  active;
        logic [POS_W-1:0]      x;
        logic [POS_W-1:0]      y;
        logic signed [V_W-1:0] vx;
        logic signed [V_W-1:0] vy;
    } fruit_slot_t;

    // Gravity grows by one unit every four cuts, clipped at g_max.
    function automatic logic [G_W-1:0] gravity(input logic [7:0]  cuts,
                                               input int unsigned g_base,
                                               input int unsigned g_max);
        logic [8:0] sum;
        sum = 9'(g_base) + {3'b000, cuts[7:2]};
        if (sum > 9'(g_max)) begin
            sum = 9'(g_max);
        end
        return sum[G_W-1:0];
    endfunction

endpackage

// File: rtl/fruit_step.sv
// Combinational single-slot integrator: gravity, motion, ceiling clamp, floor miss.
// Side-wall handling depends on FRUIT_BOUNCE_EN (bounce) or its absence (silent kill).
module fruit_step
    import fruit_pkg::*;
#(
    parameter int unsigned X_MAX = DEF_X_MAX,
    parameter int unsigned Y_MAX = DEF_Y_MAX
) (
    input  fruit_slot_t    slot_i,
    input  logic [G_W-1:0] g_i,
    output fruit_slot_t    slot_o,
    output logic           miss_o,
    output logic           kill_o
);

    localparam int unsigned EXT_W = POS_W + 2;
    localparam logic signed [EXT_W-1:0] X_HI = EXT_W'(X_MAX << FRAC_W);
    localparam logic signed [EXT_W-1:0] Y_HI = EXT_W'(Y_MAX << FRAC_W);
    localparam logic signed [V_W-1:0]   V_POS_MAX = {1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [V_W-1:0]   V_NEG_MIN = {1'b1, {(V_W-1){1'b0}}};

    logic signed [V_W:0]     vy_wide;
    logic signed [V_W-1:0]   vy_n;
    logic signed [EXT_W-1:0] x_n;
    logic signed [EXT_W-1:0] y_n;

    always_comb begin
        vy_wide = $signed({slot_i.vy[V_W-1], slot_i.vy})
                + $signed({{(V_W+1-G_W){1'b0}}, g_i});
        if (vy_wide[V_W] != vy_wide[V_W-1]) begin
            vy_n = vy_wide[V_W] ? V_NEG_MIN : V_POS_MAX;
        end else begin
            vy_n = vy_wide[V_W-1:0];
        end

        y_n = $signed({2'b00, slot_i.y}) + $signed({{(EXT_W-V_W){vy_n[V_W-1]}}, vy_n});
        x_n = $signed({2'b00, slot_i.x}) + $signed({{(EXT_W-V_W){slot_i.vx[V_W-1]}}, slot_i.vx});

        slot_o = slot_i;
        miss_o = 1'b0;
        kill_o = 1'b0;

        if (y_n < 0) begin
            slot_o.y  = '0;
            slot_o.vy = '0;
        end else begin
            slot_o.y  = y_n[POS_W-1:0];
            slot_o.vy = vy_n;
        end

        if ((y_n > Y_HI) && (vy_n > 0)) begin
            slot_o.active = 1'b0;
            miss_o        = 1'b1;
            kill_o        = 1'b1;
        end else if ((x_n < 0) || (x_n > X_HI)) begin
`ifdef FRUIT_BOUNCE_EN
            slot_o.x  = (x_n < 0) ? {POS_W{1'b0}} : X_HI[POS_W-1:0];
            slot_o.vx = (slot_i.vx == V_NEG_MIN) ? V_POS_MAX : -slot_i.vx;
`else
            slot_o.active = 1'b0;
            kill_o        = 1'b1;
`endif
        end else begin
            slot_o.x = x_n[POS_W-1:0];
        end
    end

endmodule

// File: rtl/fruit_pool.sv
// Multi-slot fruit engine: serial per-frame sweep, spawn/cut handling, registered read port.
// Optional side-wall bounce is selected with the FRUIT_BOUNCE_EN define (see fruit_step).
module fruit_pool
    import fruit_pkg::*;
#(
    parameter  int unsigned N_FRUITS = 8,
    parameter  int unsigned X_MAX    = DEF_X_MAX,
    parameter  int unsigned Y_MAX    = DEF_Y_MAX,
    parameter  int unsigned G_BASE   = 4,
    parameter  int unsigned G_MAX    = 20,
    localparam int unsigned IDX_W    = $clog2(N_FRUITS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_tick,
    input  logic                  spawn_valid,
    output logic                  spawn_ready,
    input  logic [9:0]            spawn_x,
    input  logic signed [V_W-1:0] spawn_vx,
    input  logic signed [V_W-1:0] spawn_vy,
    output logic [IDX_W-1:0]      spawn_idx,
    input  logic                  cut_valid,
    input  logic [IDX_W-1:0]      cut_idx,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [9:0]            fruit_x,
    output logic [9:0]            fruit_y,
    output logic                  fruit_active,
    output logic                  miss_pulse,
    output logic [7:0]            cut_count,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [POS_W-1:0] Y_SPAWN = POS_W'(Y_MAX << FRAC_W);

    fruit_state_t     state_q;
    logic [IDX_W-1:0] ptr_q;
    fruit_slot_t      slots_q [N_FRUITS];
    logic [7:0]       cut_count_q;
    logic             miss_q;
    logic             overrun_q;
    logic             busy_q;
    logic [9:0]       fruit_x_q;
    logic [9:0]       fruit_y_q;
    logic             fruit_active_q;

    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic             cut_hit;
    logic             cut_on_ptr;
    logic             spawn_fire;
    fruit_slot_t      spawn_slot;
    fruit_slot_t      step_out;
    logic             step_miss;
    logic             step_kill;
    logic [G_W-1:0]   g_cur;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < N_FRUITS; i++) begin
            if (!slots_q[i].active && !free_any) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cut_hit    = cut_valid && (32'(cut_idx) < N_FRUITS) && slots_q[cut_idx].active;
        cut_on_ptr = cut_hit && (cut_idx == ptr_q);
        spawn_fire = spawn_valid && spawn_ready;
        g_cur      = gravity(cut_count_q, G_BASE, G_MAX);

        spawn_slot        = '0;
        spawn_slot.active = 1'b1;
        spawn_slot.x      = {spawn_x, {FRAC_W{1'b0}}};
        spawn_slot.y      = Y_SPAWN;
        spawn_slot.vx     = spawn_vx;
        spawn_slot.vy     = spawn_vy;
    end

    fruit_step #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_step (
        .slot_i(slots_q[ptr_q]),
        .g_i   (g_cur),
        .slot_o(step_out),
        .miss_o(step_miss),
        .kill_o(step_kill)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            cut_count_q    <= '0;
            miss_q         <= 1'b0;
            overrun_q      <= 1'b0;
            busy_q         <= 1'b0;
            fruit_x_q      <= '0;
            fruit_y_q      <= '0;
            fruit_active_q <= 1'b0;
            for (int unsigned i = 0; i < N_FRUITS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            miss_q    <= 1'b0;
            overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= SWEEP;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    overrun_q <= frame_tick;
                    // A concurrent cut on this slot pre-empts the integrator result.
                    if (slots_q[ptr_q].active && !cut_on_ptr) begin
                        if (step_kill) begin
                            slots_q[ptr_q].active <= 1'b0;
                        end else begin
                            slots_q[ptr_q] <= step_out;
                        end
                        miss_q <= step_miss;
                    end
                    if (ptr_q == IDX_W'(N_FRUITS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (spawn_fire) begin
                slots_q[free_idx] <= spawn_slot;
            end

            if (cut_hit) begin
                slots_q[cut_idx].active <= 1'b0;
                if (cut_count_q != 8'hFF) begin
                    cut_count_q <= cut_count_q + 8'd1;
                end
            end

            if (32'(rd_idx) < N_FRUITS) begin
                fruit_x_q      <= slots_q[rd_idx].x[POS_W-1:FRAC_W];
                fruit_y_q      <= slots_q[rd_idx].y[POS_W-1:FRAC_W];
                fruit_active_q <= slots_q[rd_idx].active;
            end else begin
                fruit_x_q      <= '0;
                fruit_y_q      <= '0;
                fruit_active_q <= 1'b0;
            end
        end
    end

    assign spawn_ready  = (state_q == IDLE) && free_any;
    assign spawn_idx    = free_idx;
    assign fruit_x      = fruit_x_q;
    assign fruit_y      = fruit_y_q;
    assign fruit_active = fruit_active_q;
    assign miss_pulse   = miss_q;
    assign cut_count    = cut_count_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule
